pipe1_unmul_div: RTL and testbench
==================================

// Module: pipe1_unmul_div
// PURPOSE
//  Inverse of the three-stage x3*D datapath: recovers the pre-multiply term from a product.
//  Takes product F and multiplier D; returns quotient X = F / D and remainder R = F % D.
//  Iterative restoring divider, one quotient bit per clock.
//  Valid/ready handshake on both sides.
//  Sits downstream of the x3*D pipeline output; used for checking and reconstruction.
// PARAMETERS
//  N    10   operand/result width; matches the upstream datapath width
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  F/D presented
//  in_ready   out  1  divider idle, can accept
//  F          in   N  dividend (product); index 0 = MSB, same as upstream bus
//  D          in   N  divisor; index 0 = MSB
//  out_valid  out  1  X/R/div_zero valid
//  out_ready  in   1  consumer takes result
//  X          out  N  quotient
//  R          out  N  remainder
//  div_zero   out  1  D was zero for this result
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; X=0, R=0, div_zero=0, out_valid=0; in_ready=1 once rst_n=1.
//   - Reset mid-operation abandons the job; no partial result is ever presented.
//  FSM states: IDLE, CALC, DONE.
//   - IDLE: in_ready=1. On an edge with in_valid&&in_ready:
//     - Latch F, D; later input changes are ignored.
//     - If D!=0, go to CALC with bit counter=N-1.
//     - If D==0, go straight to DONE with X=all ones, R=F, div_zero=1 (latency 1 clk).
//   - CALC: in_ready=0, out_valid=0. Each edge does one restoring step:
//     - Partial remainder P is N+1 bits: P'={P[N-1:0],next dividend bit}.
//     - If P'>=D then P=P'-D and q bit=1; else P=P' and q bit=0.
//     - Quotient bits are produced MSB first. Counter decrements.
//     - The step at counter=0 moves to DONE.
//   - Latency: out_valid rises N clocks after the accept edge (D!=0).
//   - DONE: out_valid=1, in_ready=0.
//     - X, R, div_zero are held stable while out_ready=0 (no limit on stall length).
//     - Edge with out_valid&&out_ready: go to IDLE, clear out_valid.
//     - X/R/div_zero keep their last values until the next accept.
//  No overlap: a new input is accepted only in IDLE, never on the same edge as the output handshake.
//  Throughput: one job per N+2 clocks minimum.
//  All arithmetic is unsigned.
//   - Upstream product is truncated mod 2^N; X recovers x3 only when x3*D < 2^N.
//  Invariant when div_zero=0: X*D+R==F and R<D.
// STRUCTURE
//  Shared package pipe1_pkg:
//   - state enum {IDLE,CALC,DONE}.
//   - Counter width localparam CW=$clog2(N).
//   - Default width constant N_DEF=10.
//  One sub-module: pipe1_div_step.
//   - Combinational single restoring step: (P, bit, D) -> (P_next, q).
//   - Instantiated once; FSM, counter and registers live in the top.
// TESTING
//  1 F=100,D=7 accepted -> out_valid exactly 10 clks later; X=14, R=2, div_zero=0.
//  2 F=123,D=0 -> out_valid next clk; X=1023, R=123, div_zero=1.
//  3 F=1023,D=1 -> X=1023, R=0; then F=5,D=9 -> X=0, R=5.
//  4 Backpressure: hold out_ready=0 for 6 clks in DONE.
//    -> X/R stable, in_ready=0, in_valid ignored; release -> IDLE next clk.
//  5 Reset asserted at clk 4 of CALC.
//    -> all outputs 0 immediately (async); after release in_ready=1.
//    -> Next job F=55,D=5 gives X=11, R=0.
//  6 Round trip: upstream A=3,B=4,C=9,D=5 gives F=55; feed F=55,D=5 -> X=11 (=x3), R=0.
//    Random sweep with the X*D+R==F and R<D check.

Source files
------------

// File: rtl/pipe1_pkg.sv
// Shared definitions for the x3*D pipeline family: default width, FSM encoding
// and the bit-counter width derived from the default width.
package pipe1_pkg;

    localparam int N_DEF = 10;
    localparam int CW    = $clog2(N_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipe1_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit that quotient bit.
module pipe1_div_step
    import pipe1_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] p,
    input  logic         bit_in,
    input  logic [N-1:0] d,
    output logic [N-1:0] p_next,
    output logic         q
);

    logic [N:0] p_shift;

    assign p_shift = {p, bit_in};
    assign q       = (p_shift >= {1'b0, d});
    // When q=0 the shifted value is below d, so it fits in N bits.
    assign p_next  = q ? N'(p_shift - {1'b0, d}) : p_shift[N-1:0];

endmodule

// File: rtl/pipe1_unmul_div.sv
// Iterative restoring divider recovering x3 = F / D (and F % D) from the x3*D
// product, one quotient bit per clock, valid/ready on both sides.
module pipe1_unmul_div
    import pipe1_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:N-1] F,
    input  logic [0:N-1] D,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] X,
    output logic [N-1:0] R,
    output logic         div_zero
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [N-1:0]       p_q;
    logic [N-1:0]       q_q;
    logic [N-1:0]       d_q;
    logic [N-1:0]       x_q;
    logic [N-1:0]       r_q;
    logic               dz_q;
    logic [N-1:0]       p_next;
    logic               q_bit;

    // q_q starts as the dividend and fills with quotient bits as it shifts out.
    pipe1_div_step #(.N(N)) u_step (
        .p      (p_q),
        .bit_in (q_q[N-1]),
        .d      (d_q),
        .p_next (p_next),
        .q      (q_bit)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            p_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            x_q   <= '0;
            r_q   <= '0;
            dz_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_q <= D;
                        if (D == '0) begin
                            x_q   <= '1;
                            r_q   <= F;
                            dz_q  <= 1'b1;
                            state <= DONE;
                        end else begin
                            q_q   <= F;
                            p_q   <= '0;
                            cnt   <= CNT_W'(N - 1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    p_q <= p_next;
                    q_q <= {q_q[N-2:0], q_bit};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        x_q   <= {q_q[N-2:0], q_bit};
                        r_q   <= p_next;
                        dz_q  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with rst_n keeps in_ready low while reset is held.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign X         = x_q;
    assign R         = r_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_pipe1_unmul_div.sv
// Scoreboard bench for pipe1_unmul_div: expected quotient/remainder pushed on
// accept, popped and compared when out_valid appears.
module tb_pipe1_unmul_div;

    localparam int N = 10;

    typedef struct {
        int f;
        int d;
        int x;
        int r;
        bit dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:N-1] f_bus = '0;
    logic [0:N-1] d_bus = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] x_out;
    logic [N-1:0] r_out;
    logic         div_zero;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipe1_unmul_div #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .F         (f_bus),
        .D         (d_bus),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (x_out),
        .R         (r_out),
        .div_zero  (div_zero)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present one job in IDLE and push the bench's own expectation.
    task automatic send(input int f, input int d);
        exp_t e;
        e.f  = f;
        e.d  = d;
        e.dz = (d == 0);
        e.x  = (d == 0) ? (1 << N) - 1 : f / d;
        e.r  = (d == 0) ? f : f % d;
        @(negedge clk);
        check("in_ready_idle", int'(in_ready), 1);
        in_valid = 1'b1;
        f_bus    = f[N-1:0];
        d_bus    = d[N-1:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        f_bus    = N'($urandom);
        d_bus    = N'($urandom);
    endtask

    // Wait for out_valid (bounded), compare against the scoreboard, then stall
    // for `stall` clocks before completing the output handshake.
    task automatic collect(input int exp_lat, input int stall);
        exp_t e;
        int   lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("x", int'(x_out), e.x);
        check("r", int'(r_out), e.r);
        check("div_zero", int'(div_zero), int'(e.dz));
        if (!div_zero) begin
            check("inv_xdr", int'(x_out) * e.d + int'(r_out), e.f);
            check("inv_r_lt_d", int'(int'(r_out) < e.d), 1);
        end
        if (stall > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            f_bus     = 10'd777;
            d_bus     = 10'd3;
            repeat (stall) begin
                @(posedge clk);
                #1;
                check("stall_valid", int'(out_valid), 1);
                check("stall_in_ready", int'(in_ready), 0);
                check("stall_x", int'(x_out), e.x);
                check("stall_r", int'(r_out), e.r);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_valid", int'(out_valid), 0);
        check("post_hs_ready", int'(in_ready), 1);
        check("post_hs_x_hold", int'(x_out), e.x);
    endtask

    initial begin
        int f, d, x3;

        #2;
        check("rst_valid", int'(out_valid), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_r", int'(r_out), 0);
        check("rst_dz", int'(div_zero), 0);
        #10;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        send(100, 7);   collect(N, 0);
        send(123, 0);   collect(0, 0);
        send(1023, 1);  collect(N, 0);
        send(5, 9);     collect(N, 0);
        send(1000, 3);  collect(N, 6);

        // Reset four clocks into CALC abandons the job.
        send(200, 3);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_x", int'(x_out), 0);
        check("mid_rst_r", int'(r_out), 0);
        check("mid_rst_dz", int'(div_zero), 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", int'(in_ready), 1);
        send(55, 5);    collect(N, 0);

        // Round trip from the upstream multiply: x3=11, D=5 -> F=55.
        x3 = 11;
        d  = 5;
        f  = (x3 * d) % (1 << N);
        send(f, d);     collect(N, 0);
        check("round_trip_x3", int'(x_out), x3);

        for (int i = 0; i < 20; i++) begin
            f = int'($urandom_range(0, (1 << N) - 1));
            d = (i % 7 == 3) ? 0 : int'($urandom_range(1, (1 << N) - 1));
            send(f, d);
            collect((d == 0) ? 0 : N, i % 3);
        end

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
